// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction format selector and the major opcodes
// used by the instruction encoder.
package rv32i_pkg;

    typedef enum logic [2:0] {
        R_TYPE      = 3'd0,
        I_TYPE_LOAD = 3'd1,
        I_TYPE_ALU  = 3'd2,
        B_TYPE      = 3'd3,
        S_TYPE      = 3'd4
    } instr_type_t;

    localparam logic [6:0] OP_R_TYPE      = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE_LOAD = 7'b0000011;
    localparam logic [6:0] OP_I_TYPE_ALU  = 7'b0010011;
    localparam logic [6:0] OP_S_TYPE      = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE      = 7'b1100011;

endpackage

// File: rtl/instr_enc.sv
// Combinational RV32I field packer: picks the format from instr_type and
// assembles the 32-bit instruction word; unused fields are simply dropped.
module instr_enc
    import rv32i_pkg::*;
(
    input  instr_type_t  instr_type,
    input  logic [4:0]   rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic [31:0]  imm,
    output logic [31:0]  word
);

    // Only imm[12:0] can reach any format; the upper bits are sign copies.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:13];

    always_comb begin
        word = '0;
        case (instr_type)
            R_TYPE:      word = {funct7, rs2, rs1, funct3, rd, OP_R_TYPE};
            I_TYPE_LOAD: word = {imm[11:0], rs1, funct3, rd, OP_I_TYPE_LOAD};
            I_TYPE_ALU:  word = {imm[11:0], rs1, funct3, rd, OP_I_TYPE_ALU};
            S_TYPE:      word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S_TYPE};
            B_TYPE:      word = {imm[12], imm[10:5], rs2, rs1, funct3,
                                 imm[4:1], imm[11], OP_B_TYPE};
            default:     word = '0;
        endcase
    end

endmodule

// File: rtl/instr_enc_loader.sv
// Session loader: accepts one descriptor at a time, encodes it and writes it
// to consecutive instruction-memory words until in_last or capacity.
module instr_enc_loader
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_last,
    input  instr_type_t    instr_type,
    input  logic [4:0]     rd,
    input  logic [4:0]     rs1,
    input  logic [4:0]     rs2,
    input  logic [2:0]     funct3,
    input  logic [6:0]     funct7,
    input  logic [31:0]    imm,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [31:0]    mem_wdata,
    output logic [AW:0]    count,
    output logic           done,
    output logic           full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_FULL
    } state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    state_t       state_q;
    logic [AW:0]  count_q;
    logic [31:0]  word_q;
    logic         last_q;
    logic         in_ready_q;
    logic         mem_we_q;
    logic         done_q;
    logic         full_q;
    logic [31:0]  enc_word;

    instr_enc u_enc (
        .instr_type (instr_type),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .imm        (imm),
        .word       (enc_word)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FULL: begin
                    if (start) begin
                        state_q    <= S_ACCEPT;
                        count_q    <= '0;
                        in_ready_q <= 1'b1;
                        done_q     <= 1'b0;
                        full_q     <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        word_q     <= enc_word;
                        last_q     <= in_last;
                        state_q    <= S_WRITE;
                        in_ready_q <= 1'b0;
                        mem_we_q   <= 1'b1;
                    end
                end
                S_WRITE: begin
                    mem_we_q <= 1'b0;
                    count_q  <= count_q + (AW+1)'(1);
                    // in_last wins over capacity when both land on the same word
                    if (last_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (count_q == LAST_IDX) begin
                        state_q <= S_FULL;
                        full_q  <= 1'b1;
                    end else begin
                        state_q    <= S_ACCEPT;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    done_q     <= 1'b0;
                    full_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = count_q[AW-1:0];
    assign mem_wdata = word_q;
    assign count     = count_q;
    assign done      = done_q;
    assign full      = full_q;

endmodule

// File: tb/tb_instr_enc_loader.sv
// Bench for instr_enc_loader: directed vectors plus randomized sessions checked
// every cycle against a queue-based session model.
module tb_instr_enc_loader;
    import rv32i_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    instr_type_t    instr_type = R_TYPE;
    logic [4:0]     rd = '0;
    logic [4:0]     rs1 = '0;
    logic [4:0]     rs2 = '0;
    logic [2:0]     funct3 = '0;
    logic [6:0]     funct7 = '0;
    logic [31:0]    imm = '0;
    logic           in_ready;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [31:0]    mem_wdata;
    logic [AW:0]    count;
    logic           done;
    logic           full;

    int n_checks = 0;
    int n_fail = 0;
    int rst_events = 0;

    always #5 clk = ~clk;

    instr_enc_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .instr_type (instr_type),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .imm        (imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .count      (count),
        .done       (done),
        .full       (full)
    );

    // Reference encoder built from shifts and masks of the field values.
    function automatic logic [31:0] ref_enc(input instr_type_t t, input int unsigned d,
                                            input int unsigned s1, input int unsigned s2,
                                            input int unsigned f3, input int unsigned f7,
                                            input int unsigned im);
        int unsigned w;
        w = 0;
        case (t)
            R_TYPE:      w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h33;
            I_TYPE_LOAD: w = ((im & 32'hfff) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h03;
            I_TYPE_ALU:  w = ((im & 32'hfff) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
            S_TYPE:      w = (((im >> 5) & 32'h7f) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                             | ((im & 32'h1f) << 7) | 32'h23;
            B_TYPE:      w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | (s2 << 20)
                             | (s1 << 15) | (f3 << 12) | (((im >> 1) & 32'hf) << 8)
                             | (((im >> 11) & 1) << 7) | 32'h63;
            default:     w = 0;
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge arst_n);
        rst_events++;
    end

    // Session model: open flag, at most one pending word, words written, end cause.
    typedef struct {
        logic [31:0] word;
        bit          last;
    } pend_t;

    pend_t pq[$];
    bit    m_open = 1'b0;
    int    m_written = 0;
    int    m_end = 0;        // 0 none, 1 ended by in_last, 2 ended by capacity
    int    seen_rst = 0;

    initial begin : cmp
        pend_t p;
        forever begin
            @(negedge clk);
            if (seen_rst != rst_events || !arst_n) begin
                seen_rst  = rst_events;
                pq.delete();
                m_open    = 1'b0;
                m_written = 0;
                m_end     = 0;
            end
            chk("in_ready", 32'(in_ready), 32'(m_open && pq.size() == 0));
            chk("mem_we", 32'(mem_we), 32'(pq.size() != 0));
            if (pq.size() != 0) begin
                chk("mem_addr", 32'(mem_addr), 32'(m_written % DEPTH));
                chk("mem_wdata", mem_wdata, pq[0].word);
            end
            chk("count", 32'(count), 32'(m_written));
            chk("done", 32'(done), 32'(m_end == 1));
            chk("full", 32'(full), 32'(m_end == 2));
            if (arst_n) begin
                if (pq.size() != 0) begin
                    p = pq.pop_front();
                    m_written++;
                    if (p.last) begin
                        m_open = 1'b0;
                        m_end  = 1;
                    end else if (m_written == DEPTH) begin
                        m_open = 1'b0;
                        m_end  = 2;
                    end
                end else if (m_open && in_valid) begin
                    p.word = ref_enc(instr_type, rd, rs1, rs2, funct3, funct7, imm);
                    p.last = in_last;
                    pq.push_back(p);
                end else if (!m_open && start) begin
                    m_open    = 1'b1;
                    m_written = 0;
                    m_end     = 0;
                end
            end
        end
    end

    // All directed tasks start and end 1 time unit after a rising edge.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input instr_type_t t, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im, input logic lst);
        bit ok;
        ok = 1'b0;
        instr_type = t; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im; in_last = lst;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wr_chk(input string name, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        @(negedge clk);
        chk({name, "_we"}, 32'(mem_we), 32'd1);
        chk({name, "_addr"}, 32'(mem_addr), exp_addr);
        chk({name, "_data"}, mem_wdata, exp_data);
        @(posedge clk); #1;
    endtask

    initial begin
        chk("model_r", ref_enc(R_TYPE, 3, 1, 2, 0, 0, 0), 32'h002081B3);
        chk("model_s", ref_enc(S_TYPE, 0, 1, 2, 2, 0, 12), 32'h0020A623);
        chk("model_b", ref_enc(B_TYPE, 0, 1, 2, 0, 0, 32'hFFFFFFFC), 32'hFE208EE3);

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done_full", 32'({done, full}), 32'd0);
        #12 arst_n = 1'b1;
        @(posedge clk); #1;

        // R then B (last) in one session
        do_start();
        send(R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        wr_chk("r_type", 0, 32'h002081B3);
        send(B_TYPE, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1'b1);
        wr_chk("b_type", 1, 32'hFE208EE3);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_count", 32'(count), 32'd2);

        // load then store with in_last
        do_start();
        send(I_TYPE_LOAD, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 32'd8, 1'b0);
        wr_chk("i_load", 0, 32'h0080A283);
        send(S_TYPE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12, 1'b1);
        wr_chk("s_type", 1, 32'h0020A623);
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_full", 32'(full), 32'd0);
        chk("s2_count", 32'(count), 32'd2);

        // capacity reached without in_last; fifth descriptor must stall
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(I_TYPE_ALU, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(i * 3), 1'b0);
            wr_chk("fill", 32'(i), ref_enc(I_TYPE_ALU, i + 1, 2, 0, 0, 0, i * 3));
        end
        chk("cap_full", 32'(full), 32'd1);
        chk("cap_done", 32'(done), 32'd0);
        chk("cap_count", 32'(count), 32'd4);
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("cap_in_ready", 32'(in_ready), 32'd0);
            chk("cap_no_write", 32'(mem_we), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // in_last on the DEPTH-th word takes priority over full
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(R_TYPE, 5'(i), 5'(i + 8), 5'(i + 16), 3'(i), 7'h20, 32'd0, i == 3);
            wr_chk("last4", 32'(i), ref_enc(R_TYPE, i, i + 8, i + 16, i, 32'h20, 0));
        end
        chk("last4_done", 32'(done), 32'd1);
        chk("last4_full", 32'(full), 32'd0);
        chk("last4_count", 32'(count), 32'd4);

        // reset during a write cycle aborts it
        do_start();
        send(R_TYPE, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        #1 arst_n = 1'b0;
        #1;
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        #1 arst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_ready", 32'(in_ready), 32'd0);
        chk("abort_idle_flags", 32'({done, full}), 32'd0);
        @(posedge clk); #1;
        chk("abort_no_retry", 32'(mem_we), 32'd0);
        do_start();
        send(R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        wr_chk("after_rst", 0, 32'h002081B3);

        // randomized traffic, including stray starts and a few mid-cycle resets
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            start      = ($urandom_range(0, 9) == 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            in_last    = ($urandom_range(0, 4) == 0);
            instr_type = instr_type_t'($urandom_range(0, 4));
            rd         = 5'($urandom);
            rs1        = 5'($urandom);
            rs2        = 5'($urandom);
            funct3     = 3'($urandom);
            funct7     = 7'($urandom);
            imm        = $urandom;
            if (c % 500 == 250) begin
                #1 arst_n = 1'b0;
                #1 arst_n = 1'b1;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_enc_loader.md
INSTR_ENC_LOADER -- requirements
Module: instr_enc_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the instruction-memory capacity in 32-bit words (power of two, at least 2).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), meaning the word-address width.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have arst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have start  input  1  single-cycle pulse that begins a load session.
REQ-006 SHALL have in_valid  input  1  descriptor valid.
REQ-007 SHALL have in_ready  output  1  descriptor accepted when in_valid and in_ready are both high.
REQ-008 SHALL have in_last  input  1  marks the final descriptor of the session.
REQ-009 SHALL have instr_type  input  instr_type_t  R_TYPE, I_TYPE_LOAD, I_TYPE_ALU, B_TYPE or S_TYPE.
REQ-010 SHALL have rd, rs1, rs2  input  5 each  register indices.
REQ-011 SHALL have funct3  input  3  and funct7  input  7  function fields.
REQ-012 SHALL have imm  input  32  sign-extended immediate, in bytes for B_TYPE.
REQ-013 SHALL have mem_we  output  1, mem_addr  output  AW, and mem_wdata  output  32  instruction-memory write port.
REQ-014 SHALL have count  output  AW+1  number of words written in the current session.
REQ-015 SHALL have done  output  1  session complete, and full  output  1  capacity reached before in_last.

Function
REQ-016 SHALL implement the FSM IDLE -> ACCEPT on start; ACCEPT -> WRITE on a handshake; WRITE -> ACCEPT after the write; WRITE -> DONE when the written descriptor had in_last; WRITE -> FULL when count reaches DEPTH without in_last; DONE or FULL -> IDLE on start.
REQ-017 SHALL drive in_ready high only in ACCEPT, so at most one descriptor is in flight.
REQ-018 SHALL register the encoded word and its last flag at the handshake edge, and assert mem_we for exactly the following cycle (WRITE), giving a latency of 1 cycle from accept to write.
REQ-019 SHALL encode with these opcodes: R 0110011, I_TYPE_LOAD 0000011, I_TYPE_ALU 0010011, S 0100011, B 1100011.
REQ-020 SHALL encode R as {funct7,rs2,rs1,funct3,rd,op}.
REQ-021 SHALL encode I as {imm[11:0],rs1,funct3,rd,op}.
REQ-022 SHALL encode S as {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
REQ-023 SHALL encode B as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
REQ-024 SHALL ignore fields that the selected format does not use; imm bits above the field width SHALL be discarded.
REQ-025 SHALL set mem_addr to count[AW-1:0] during WRITE and increment count by 1 at the end of WRITE.
REQ-026 SHALL clear count to 0 on every start accepted in IDLE, DONE or FULL.
REQ-027 SHALL ignore start while in ACCEPT or WRITE.
REQ-028 SHALL give in_last priority when the DEPTH-th word carries in_last: the state goes to DONE and full stays 0.
REQ-029 SHALL hold done high throughout DONE and full high throughout FULL, and hold both low in every other state.
REQ-030 SHALL ignore in_valid outside ACCEPT, with no write.

Reset
REQ-031 SHALL on arst_n low, asynchronously and immediately, enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0 and full=0.
REQ-032 SHALL treat reset asserted mid-WRITE as abort: mem_we drops at once and nothing is retried after release.

Structure
REQ-033 SHALL take instr_type_t from rv32i_pkg, and the five 7-bit opcode constants SHALL be added to rv32i_pkg.
REQ-034 SHALL place the combinational field packing in one sub-module, instr_enc (instr_type and fields -> 32-bit word); the FSM, counter and registers stay in instr_enc_loader.

Verification
REQ-035 SHALL cover: start, then R_TYPE rd=3 rs1=1 rs2=2 funct3=0 funct7=0 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x002081B3.
REQ-036 SHALL cover: I_TYPE_LOAD rd=5 rs1=1 funct3=2 imm=8, then S_TYPE rs1=1 rs2=2 funct3=2 imm=12 with in_last -> writes 0x0080A283 at addr 0 and 0x0020A623 at addr 1; done=1; count=2.
REQ-037 SHALL cover: B_TYPE rs1=1 rs2=2 funct3=0 imm=-4 -> mem_wdata=0xFE208EE3.
REQ-038 SHALL cover: DEPTH=4 with 5 descriptors and no in_last -> 4 writes at addr 0..3, full=1, in_ready=0; the 5th descriptor is never accepted.
REQ-039 SHALL cover: DEPTH=4 with in_last on the 4th descriptor -> done=1 and full=0.
REQ-040 SHALL cover: arst_n pulsed low in the WRITE cycle -> mem_we=0 in the same cycle; after release the block is in IDLE with count=0; a new start re-writes from addr 0.
